// File: rtl/ace_pkg.sv
// rtl/ace_pkg.sv - shared ACE acknowledge-tracking types and constants
package ace_pkg;

    // Bit positions inside the sticky acknowledge error vector
    typedef enum logic [1:0] {
        ACK_ERR_RACK_UFL = 2'd0,
        ACK_ERR_WACK_UFL = 2'd1,
        ACK_ERR_R_TO     = 2'd2,
        ACK_ERR_B_TO     = 2'd3
    } ack_err_e;

    localparam int AckErrWidth = 4;

endpackage

// File: rtl/ace_ack_counter.sv
// rtl/ace_ack_counter.sv - per-channel pending-ack counter with underflow and timeout detection
module ace_ack_counter #(
    parameter int MaxPending = 16,
    parameter int AckTimeout = 256,
    localparam int CntW      = $clog2(MaxPending + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            done_i,
    input  logic            ack_i,
    input  logic            clr_err_i,
    output logic [CntW-1:0] count_o,
    output logic            stall_o,
    output logic            underflow_err_o,
    output logic            timeout_err_o
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxPending);
    // A zero timeout disables the timer; keep the register one bit wide so it still elaborates
    localparam int              TW     = (AckTimeout > 0) ? $clog2(AckTimeout + 1) : 1;
    localparam logic [TW-1:0]   TMax   = TW'(AckTimeout);

    logic [CntW-1:0] count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ufl_q, ufl_d, ufl_set;
    logic            to_q, to_d, to_set;

    // Pending count: done adds, ack retires; an ack with nothing pending is an underflow
    always_comb begin
        count_d = count_q;
        ufl_set = 1'b0;
        case ({done_i, ack_i})
            2'b10: if (count_q != MaxCnt) count_d = count_q + 1'b1;
            2'b01: begin
                if (count_q != '0) count_d = count_q - 1'b1;
                else               ufl_set = 1'b1;
            end
            2'b11: begin
                // Same-cycle ack cannot belong to this completion, so with nothing pending it is spurious
                if (count_q == '0) begin
                    count_d = CntW'(1);
                    ufl_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Ack-age timer: restarts on every ack or when idle, fires once on reaching the limit and then holds
    always_comb begin
        timer_d = timer_q;
        to_set  = 1'b0;
        if (AckTimeout == 0 || count_q == '0 || ack_i) begin
            timer_d = '0;
        end else if (timer_q != TMax) begin
            timer_d = timer_q + 1'b1;
            to_set  = (timer_q == TMax - 1'b1);
        end
    end

    // Sticky errors: clear request loses against an error raised in the same cycle
    always_comb begin
        ufl_d = (ufl_q & ~clr_err_i) | ufl_set;
        to_d  = (to_q  & ~clr_err_i) | to_set;
    end

    // State registers with synchronous reset discarding all pending state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            timer_q <= '0;
            ufl_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            timer_q <= timer_d;
            ufl_q   <= ufl_d;
            to_q    <= to_d;
        end
    end

    assign count_o         = count_q;
    assign stall_o         = (count_q == MaxCnt);
    assign underflow_err_o = ufl_q;
    assign timeout_err_o   = to_q;

endmodule

// File: rtl/ace_ack_tracker.sv
// rtl/ace_ack_tracker.sv - tracks ACE RACK/WACK acknowledges against R/B completions
module ace_ack_tracker
    import ace_pkg::*;
#(
    parameter int MaxPending = 16,
    parameter int AckTimeout = 256,
    localparam int CntW      = $clog2(MaxPending + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   r_valid_i,
    input  logic                   r_ready_i,
    input  logic                   r_last_i,
    input  logic                   b_valid_i,
    input  logic                   b_ready_i,
    input  logic                   rack_i,
    input  logic                   wack_i,
    output logic [CntW-1:0]        r_pending_o,
    output logic [CntW-1:0]        b_pending_o,
    output logic                   r_stall_o,
    output logic                   b_stall_o,
    output logic                   idle_o,
    input  logic                   clr_err_i,
    output logic [AckErrWidth-1:0] err_o
);

    // A read completes on its last-beat handshake; a write on its B handshake
    logic r_done, b_done;
    assign r_done = r_valid_i & r_ready_i & r_last_i;
    assign b_done = b_valid_i & b_ready_i;

    logic r_ufl, r_to, b_ufl, b_to;

    ace_ack_counter #(
        .MaxPending (MaxPending),
        .AckTimeout (AckTimeout)
    ) u_r_cnt (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .done_i          (r_done),
        .ack_i           (rack_i),
        .clr_err_i       (clr_err_i),
        .count_o         (r_pending_o),
        .stall_o         (r_stall_o),
        .underflow_err_o (r_ufl),
        .timeout_err_o   (r_to)
    );

    ace_ack_counter #(
        .MaxPending (MaxPending),
        .AckTimeout (AckTimeout)
    ) u_b_cnt (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .done_i          (b_done),
        .ack_i           (wack_i),
        .clr_err_i       (clr_err_i),
        .count_o         (b_pending_o),
        .stall_o         (b_stall_o),
        .underflow_err_o (b_ufl),
        .timeout_err_o   (b_to)
    );

    assign idle_o = (r_pending_o == '0) && (b_pending_o == '0);

    // Pack per-channel sticky flags into the shared error vector
    always_comb begin
        err_o                        = '0;
        err_o[int'(ACK_ERR_RACK_UFL)] = r_ufl;
        err_o[int'(ACK_ERR_WACK_UFL)] = b_ufl;
        err_o[int'(ACK_ERR_R_TO)]     = r_to;
        err_o[int'(ACK_ERR_B_TO)]     = b_to;
    end

    // Upstream must honour the stalls; a completion while stalled would be silently dropped
    a_r_stall_respected: assert property (@(posedge clk_i) disable iff (rst_i) !(r_done && r_stall_o));
    a_b_stall_respected: assert property (@(posedge clk_i) disable iff (rst_i) !(b_done && b_stall_o));
    a_rack_known:        assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(rack_i));
    a_wack_known:        assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(wack_i));

endmodule

// File: tb/tb_ace_ack_tracker.sv
// tb/tb_ace_ack_tracker.sv - self-checking bench for ace_ack_tracker
module tb_ace_ack_tracker;

    localparam int MP = 6;
    localparam int AT = 8;
    localparam int CW = $clog2(MP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r_valid = 1'b0, r_ready = 1'b0, r_last = 1'b0;
    logic          b_valid = 1'b0, b_ready = 1'b0;
    logic          rack = 1'b0, wack = 1'b0, clr_err = 1'b0;
    logic [CW-1:0] r_pending, b_pending;
    logic          r_stall, b_stall, idle;
    logic [3:0]    err;

    int checks = 0;
    int passes = 0;

    // Reference state: pending counts, cycles since last ack while busy, sticky errors
    int         m_rc = 0, m_bc = 0, m_ra = 0, m_ba = 0;
    logic [3:0] m_err = 4'b0;

    ace_ack_tracker #(.MaxPending(MP), .AckTimeout(AT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .r_valid_i   (r_valid),
        .r_ready_i   (r_ready),
        .r_last_i    (r_last),
        .b_valid_i   (b_valid),
        .b_ready_i   (b_ready),
        .rack_i      (rack),
        .wack_i      (wack),
        .r_pending_o (r_pending),
        .b_pending_o (b_pending),
        .r_stall_o   (r_stall),
        .b_stall_o   (b_stall),
        .idle_o      (idle),
        .clr_err_i   (clr_err),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    logic [2*CW+6:0] obs;
    assign obs = {r_pending, b_pending, r_stall, b_stall, idle, err};

    function automatic logic [2*CW+6:0] exp_vec(int rc, int bc, logic [3:0] e);
        return {CW'(rc), CW'(bc), rc == MP, bc == MP, (rc == 0 && bc == 0), e};
    endfunction

    task automatic model_chan(inout int cnt, inout int age, input bit done, input bit ack,
                              output bit ufl, output bit to);
        int old;
        old = cnt;
        ufl = ack && (cnt == 0);
        to  = 1'b0;
        if (done && !ack)       cnt = (cnt < MP) ? cnt + 1 : cnt;
        else if (ack && !done)  cnt = (cnt > 0) ? cnt - 1 : 0;
        else if (done && ack && cnt == 0) cnt = 1;
        if (old == 0 || ack) age = 0;
        else if (age < AT) begin
            age = age + 1;
            to  = (age == AT);
        end
    endtask

    task automatic step(input bit rv, input bit rr, input bit rl, input bit bv, input bit br,
                        input bit ra, input bit wa, input bit clr, input bit rs);
        bit ruf, rto, wuf, bto;
        r_valid = rv; r_ready = rr; r_last = rl;
        b_valid = bv; b_ready = br;
        rack = ra; wack = wa; clr_err = clr; rst = rs;
        @(posedge clk);
        if (rs) begin
            m_rc = 0; m_bc = 0; m_ra = 0; m_ba = 0; m_err = 4'b0;
        end else begin
            model_chan(m_rc, m_ra, rv & rr & rl, ra, ruf, rto);
            model_chan(m_bc, m_ba, bv & br, wa, wuf, bto);
            if (clr) m_err = 4'b0;
            m_err = m_err | {bto, rto, wuf, ruf};
        end
        #1;
    endtask

    task automatic step_s(input bit rd, input bit bd, input bit ra, input bit wa,
                          input bit clr, input bit rs);
        step(rd, rd, rd, bd, bd, ra, wa, clr, rs);
    endtask

    task automatic test_reset();
        step_s(0, 0, 0, 0, 0, 1);
        step_s(0, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== exp_vec(0, 0, 4'b0))
            $display("FAIL reset_state: got %h expected %h", obs, exp_vec(0, 0, 4'b0));
        else passes++;
        step_s(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_vec(0, 0, 4'b0))
            $display("FAIL post_reset_idle: got %h expected %h", obs, exp_vec(0, 0, 4'b0));
        else passes++;
    endtask

    task automatic test_read_acks();
        int exp_r[7] = '{1, 2, 3, 3, 2, 1, 0};
        for (int i = 0; i < 7; i++) begin
            step_s(i < 3, 0, i >= 4, 0, 0, 0);
            checks++;
            if (obs !== exp_vec(exp_r[i], 0, 4'b0))
                $display("FAIL read_acks[%0d]: got %h expected %h", i, obs, exp_vec(exp_r[i], 0, 4'b0));
            else passes++;
        end
    endtask

    task automatic test_b_stall();
        for (int i = 1; i <= MP; i++) begin
            step_s(0, 1, 0, 0, 0, 0);
            checks++;
            if (b_stall !== (i == MP) || b_pending !== CW'(i))
                $display("FAIL b_fill[%0d]: got stall=%b cnt=%0d expected stall=%b cnt=%0d",
                         i, b_stall, b_pending, (i == MP), i);
            else passes++;
        end
        step_s(0, 0, 0, 1, 0, 0);
        checks++;
        if (obs !== exp_vec(0, MP - 1, 4'b0))
            $display("FAIL b_unstall: got %h expected %h", obs, exp_vec(0, MP - 1, 4'b0));
        else passes++;
        for (int i = 0; i < MP - 1; i++) step_s(0, 0, 0, 1, 0, 0);
        checks++;
        if (obs !== exp_vec(0, 0, 4'b0))
            $display("FAIL b_drain: got %h expected %h", obs, exp_vec(0, 0, 4'b0));
        else passes++;
    endtask

    task automatic test_wack_underflow();
        step_s(0, 0, 0, 1, 0, 0);
        checks++;
        if (obs !== exp_vec(0, 0, 4'b0010))
            $display("FAIL wack_ufl_set: got %h expected %h", obs, exp_vec(0, 0, 4'b0010));
        else passes++;
        step_s(0, 0, 0, 0, 0, 0);
        step_s(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_vec(0, 0, 4'b0010))
            $display("FAIL wack_ufl_sticky: got %h expected %h", obs, exp_vec(0, 0, 4'b0010));
        else passes++;
        step_s(0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== exp_vec(0, 0, 4'b0))
            $display("FAIL wack_ufl_clear: got %h expected %h", obs, exp_vec(0, 0, 4'b0));
        else passes++;
    endtask

    task automatic test_timeout();
        step_s(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= AT; i++) begin
            step_s(0, 0, 0, 0, 0, 0);
            checks++;
            if (err[2] !== (i == AT))
                $display("FAIL r_timeout_edge[%0d]: got %b expected %b", i, err[2], (i == AT));
            else passes++;
        end
        step_s(0, 0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_vec(0, 0, 4'b0100))
            $display("FAIL r_timeout_late_ack: got %h expected %h", obs, exp_vec(0, 0, 4'b0100));
        else passes++;
        // Clear and raise a new underflow in the same cycle: the new error must survive
        step_s(0, 0, 1, 0, 1, 0);
        checks++;
        if (obs !== exp_vec(0, 0, 4'b0001))
            $display("FAIL clr_vs_new_err: got %h expected %h", obs, exp_vec(0, 0, 4'b0001));
        else passes++;
        step_s(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_simultaneous();
        step_s(1, 0, 0, 0, 0, 0);
        step_s(1, 0, 0, 0, 0, 0);
        step_s(1, 0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_vec(2, 0, 4'b0))
            $display("FAIL simul_nonzero: got %h expected %h", obs, exp_vec(2, 0, 4'b0));
        else passes++;
        step_s(0, 0, 1, 0, 0, 0);
        step_s(0, 0, 1, 0, 0, 0);
        step_s(1, 0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_vec(1, 0, 4'b0001))
            $display("FAIL simul_zero: got %h expected %h", obs, exp_vec(1, 0, 4'b0001));
        else passes++;
        step_s(0, 0, 1, 0, 1, 0);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) step_s(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < AT; i++) step_s(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_vec(5, 0, 4'b0100))
            $display("FAIL pre_reset_state: got %h expected %h", obs, exp_vec(5, 0, 4'b0100));
        else passes++;
        step_s(0, 0, 1, 1, 0, 1);
        checks++;
        if (obs !== exp_vec(0, 0, 4'b0))
            $display("FAIL mid_reset: got %h expected %h", obs, exp_vec(0, 0, 4'b0));
        else passes++;
        step_s(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit rv, rr, rl, bv, br, ra, wa, clr;
        for (int i = 0; i < 600; i++) begin
            rv  = ($urandom_range(0, 1) == 1);
            rr  = ($urandom_range(0, 3) != 0);
            rl  = ($urandom_range(0, 1) == 1);
            if (m_rc >= MP) rl = 1'b0;
            bv  = (m_bc < MP) && ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 1) == 1);
            ra  = ($urandom_range(0, 4) == 0);
            wa  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 15) == 0);
            step(rv, rr, rl, bv, br, ra, wa, clr, 1'b0);
            checks++;
            if (obs !== exp_vec(m_rc, m_bc, m_err))
                $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_vec(m_rc, m_bc, m_err));
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_read_acks();
        test_b_stall();
        test_wack_underflow();
        test_timeout();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
